mul_accumulator: RTL and testbench
==================================

MUL_ACCUMULATOR -- requirements
Module: mul_accumulator

Parameters
REQ-001 The block SHALL have parameter SIZE, default 16, giving the multiplier operand width; the product width is 2*SIZE.
REQ-002 The block SHALL have parameter COUNT, default 4, giving the number of products summed per result; legal range is 2..256.

Interface
REQ-003 Clock  input  1  sole clock; all state changes on the rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 iClear  input  1  synchronous abort; discards the partial sum.
REQ-006 iProduct  input  2*SIZE  unsigned product from the upstream multiplier stage.
REQ-007 iValid  input  1  iProduct is valid this cycle.
REQ-008 oReady  output  1  block accepts iProduct this cycle.
REQ-009 oSum  output  2*SIZE+8  completed sum of COUNT products, unsigned.
REQ-010 oValid  output  1  oSum is valid.
REQ-011 iReady  input  1  downstream consumes oSum this cycle.
REQ-012 oIndex  output  8  number of products accepted into the current partial sum.

Function
REQ-013 The block SHALL implement a two-state FSM: ACCUM and DONE.
REQ-014 An input handshake SHALL occur on a rising edge where iValid=1, oReady=1 and iClear=0.
REQ-015 In ACCUM, oReady SHALL be 1 and oValid SHALL be 0.
REQ-016 Each input handshake in ACCUM SHALL add zero-extended iProduct to the internal accumulator and increment oIndex by 1.
REQ-017 On the handshake that makes oIndex reach COUNT, the block SHALL do the following on that same edge:
- load oSum with accumulator+iProduct;
- set oValid=1;
- clear the accumulator and oIndex to 0;
- enter DONE.
REQ-018 Result latency SHALL be one cycle: oValid is high in the cycle after the COUNT-th input handshake.
REQ-019 In DONE, oReady SHALL be 0.
REQ-020 In DONE, oSum and oValid SHALL hold stable until an output handshake (oValid=1 and iReady=1).
REQ-021 On the output handshake edge, the block SHALL clear oValid and return to ACCUM.
REQ-022 There SHALL be exactly one bubble cycle between results; no input is accepted in the output-handshake cycle.
REQ-023 iValid=0 in ACCUM SHALL leave the accumulator and oIndex unchanged, with no timeout.
REQ-024 The accumulator SHALL be 2*SIZE+8 bits wide so it cannot overflow for COUNT<=256; no saturation or wrap logic is needed.
REQ-025 iClear=1 SHALL take priority over any handshake, in either state. On that edge it SHALL:
- clear the accumulator and oIndex to 0;
- set oValid=0;
- enter ACCUM.
REQ-026 iClear=1 SHALL leave oSum at its last value.
REQ-027 iProduct SHALL be ignored whenever iValid=0, oReady=0 or iClear=1.
REQ-028 oSum SHALL be driven from a register; no combinational path from iProduct to oSum is permitted.

Reset
REQ-029 Reset=1 SHALL immediately, without waiting for a clock edge:
- force the FSM to ACCUM;
- set the accumulator, oIndex and oSum to 0;
- set oValid=0.
REQ-030 While in reset, oReady SHALL be 0.
REQ-031 oReady SHALL be 1 from the first rising edge after Reset deasserts.
REQ-032 Reset asserted mid-accumulation or in DONE SHALL discard all state with no output handshake.

Verification (SIZE=16, COUNT=4)
REQ-033 Basic sum:
- Stimulus: products 1, 2, 3, 4 on consecutive cycles, iReady=1.
- Response: oValid=1 with oSum=10 one cycle after the 4th product; oValid drops the next cycle.
REQ-034 Maximum values:
- Stimulus: four products of 0xFFFFFFFF.
- Response: oSum=0x3FFFFFFFC, with no truncation.
REQ-035 Backpressure:
- Stimulus: iReady=0 for 5 cycles after the result.
- Response: oSum and oValid stable, oReady=0, iValid pulses ignored; the single iReady cycle returns to ACCUM.
REQ-036 Gaps:
- Stimulus: products 5, gap, gap, 6, gap, 7, 8.
- Response: oIndex steps 1, 1, 1, 2, 2, 3, 0; oSum=26.
REQ-037 Clear mid-block:
- Stimulus: 2 products, then iClear=1 concurrent with iValid, then 1, 1, 1, 1.
- Response: oSum=4.
REQ-038 Asynchronous reset:
- Stimulus: Reset pulse between clock edges while in DONE.
- Response: oValid and oSum go to 0 before the next edge; oReady=1 after the first edge post-release.

Source files
------------

// File: rtl/mul_accumulator.sv
// Sums COUNT unsigned products per result; holds each result until the
// downstream side takes it, then resumes accumulating after one bubble cycle.
module mul_accumulator #(
  parameter int SIZE  = 16,
  parameter int COUNT = 4
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                iClear,
  input  logic [2*SIZE-1:0]   iProduct,
  input  logic                iValid,
  output logic                oReady,
  output logic [2*SIZE+7:0]   oSum,
  output logic                oValid,
  input  logic                iReady,
  output logic [7:0]          oIndex
);

  localparam int          ACC_W = 2*SIZE + 8;
  localparam logic [7:0]  LAST  = 8'(COUNT - 1);

  typedef enum logic {ACCUM, DONE} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   sum_q, sum_d;
  logic [7:0]         index_q, index_d;
  logic               valid_q, valid_d;
  logic               ready_q, ready_d;
  logic [ACC_W-1:0]   prod_ext;
  logic               in_hs, out_hs;

  assign prod_ext = {8'd0, iProduct};
  assign in_hs    = iValid & ready_q & ~iClear;
  assign out_hs   = valid_q & iReady;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    index_d = index_q;
    valid_d = valid_q;
    if (iClear) begin
      acc_d   = '0;
      index_d = '0;
      valid_d = 1'b0;
      state_d = ACCUM;
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_hs) begin
            if (index_q == LAST) begin
              sum_d   = acc_q + prod_ext;
              valid_d = 1'b1;
              acc_d   = '0;
              index_d = '0;
              state_d = DONE;
            end else begin
              acc_d   = acc_q + prod_ext;
              index_d = index_q + 8'd1;
            end
          end
        end
        DONE: begin
          if (out_hs) begin
            valid_d = 1'b0;
            state_d = ACCUM;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
    // Registered ready: low through reset, high from the first edge in ACCUM.
    ready_d = (state_d == ACCUM);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      sum_q   <= '0;
      index_q <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      index_q <= index_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign oReady = ready_q;
  assign oSum   = sum_q;
  assign oValid = valid_q;
  assign oIndex = index_q;

endmodule

// File: tb/tb_mul_accumulator.sv
// Directed and random stimulus for mul_accumulator, checked against a
// transaction-level model that keeps the accepted products in a queue.
module tb_mul_accumulator;

  localparam int SIZE  = 16;
  localparam int COUNT = 4;

  logic               Clock = 1'b0;
  logic               Reset;
  logic               iClear;
  logic [2*SIZE-1:0]  iProduct;
  logic               iValid;
  logic               oReady;
  logic [2*SIZE+7:0]  oSum;
  logic               oValid;
  logic               iReady;
  logic [7:0]         oIndex;

  mul_accumulator #(.SIZE(SIZE), .COUNT(COUNT)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .iClear   (iClear),
    .iProduct (iProduct),
    .iValid   (iValid),
    .oReady   (oReady),
    .oSum     (oSum),
    .oValid   (oValid),
    .iReady   (iReady),
    .oIndex   (oIndex)
  );

  always #5 Clock = ~Clock;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state
  logic [63:0] parts[$];
  logic [63:0] m_sum;
  logic        m_valid;
  logic        m_ready;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".oValid"}, 64'(oValid), 64'(m_valid));
    check({tag, ".oReady"}, 64'(oReady), 64'(m_ready));
    check({tag, ".oSum"},   64'(oSum),   m_sum);
    check({tag, ".oIndex"}, 64'(oIndex), 64'(parts.size()));
  endtask

  task automatic model_reset();
    parts.delete();
    m_sum   = '0;
    m_valid = 1'b0;
    m_ready = 1'b0;
  endtask

  // Apply one cycle of inputs, advance the model by the same rules, compare.
  task automatic cycle(input string tag, input logic c, input logic v,
                       input logic [31:0] p, input logic r);
    logic [63:0] total;
    iClear = c; iValid = v; iProduct = p; iReady = r;
    @(posedge Clock);
    #1;
    if (c) begin
      parts.delete();
      m_valid = 1'b0;
    end else if (m_ready && v) begin
      parts.push_back(64'(p));
      if (parts.size() == COUNT) begin
        total = '0;
        foreach (parts[i]) total += parts[i];
        m_sum   = total;
        m_valid = 1'b1;
        parts.delete();
      end
    end else if (m_valid && r) begin
      m_valid = 1'b0;
    end
    m_ready = !m_valid;
    check_all(tag);
  endtask

  initial begin
    Reset = 1'b1; iClear = 0; iValid = 0; iProduct = '0; iReady = 0;
    model_reset();
    #12;
    check_all("reset");
    Reset = 1'b0;

    // Basic sum: 1,2,3,4 then drop of oValid
    cycle("basic0", 0, 0, 0, 1);
    cycle("basic1", 0, 1, 1, 1);
    cycle("basic2", 0, 1, 2, 1);
    cycle("basic3", 0, 1, 3, 1);
    cycle("basic4", 0, 1, 4, 1);
    check("basic_sum10", 64'(oSum), 64'd10);
    cycle("basic5", 0, 1, 9, 1);
    check("basic_drop", 64'(oValid), 64'd0);

    // Maximum products
    for (int i = 0; i < 4; i++) cycle("max", 0, 1, 32'hFFFF_FFFF, 0);
    check("max_sum", 64'(oSum), 64'h3_FFFF_FFFC);

    // Backpressure with ignored iValid pulses
    for (int i = 0; i < 5; i++) cycle("bp", 0, i[0], 32'h55, 0);
    check("bp_ready", 64'(oReady), 64'd0);
    cycle("bp_release", 0, 1, 32'h77, 1);
    cycle("bp_back", 0, 0, 0, 0);
    check("bp_ready_again", 64'(oReady), 64'd1);

    // Gaps: 5,-,-,6,-,7,8
    cycle("gap", 0, 1, 5, 1);
    cycle("gap", 0, 0, 99, 1);
    cycle("gap", 0, 0, 99, 1);
    cycle("gap", 0, 1, 6, 1);
    check("gap_idx2", 64'(oIndex), 64'd2);
    cycle("gap", 0, 0, 99, 1);
    cycle("gap", 0, 1, 7, 1);
    cycle("gap", 0, 1, 8, 1);
    check("gap_sum26", 64'(oSum), 64'd26);
    check("gap_idx0", 64'(oIndex), 64'd0);
    cycle("gap_out", 0, 0, 0, 1);

    // Clear mid-block concurrent with iValid
    cycle("clr", 0, 1, 100, 1);
    cycle("clr", 0, 1, 200, 1);
    cycle("clr_hit", 1, 1, 300, 1);
    for (int i = 0; i < 4; i++) cycle("clr_after", 0, 1, 1, 0);
    check("clr_sum4", 64'(oSum), 64'd4);

    // Asynchronous reset while in DONE
    check("pre_rst_valid", 64'(oValid), 64'd1);
    #1 Reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    #1 Reset = 1'b0;
    cycle("post_rst", 0, 1, 42, 1);
    check("post_rst_ready", 64'(oReady), 64'd1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] p;
      p = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      cycle("rand", ($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 7),
            p, ($urandom_range(0, 1) == 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
